led_seq_ctrl: RTL and testbench

- Mode scheduler for the 4-LED bank: generates the step tick and sequences the LED pattern through one of four selectable modes.
- Accepts mode-change requests from a key/debounce front end and applies them only on step boundaries, so a pattern never changes mid-step.
- Drives active-low LED pins directly.

---
 rtl/led_pkg.sv | 42 ++++
 rtl/led_tick_gen.sv | 32 +++
 rtl/led_seq_ctrl.sv | 148 ++++++++++++++
 tb/tb_led_seq_ctrl.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : led_pkg
//  Brief    : Shared widths, mode/state encodings and start patterns for the
//             LED sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package led_pkg;

    localparam int LED_W = 4;

    typedef enum logic [1:0] {
        MODE_SHL   = 2'd0,
        MODE_SHR   = 2'd1,
        MODE_PING  = 2'd2,
        MODE_BLINK = 2'd3
    } mode_e;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam logic [LED_W-1:0] START_SHL   = 4'b0001;
    localparam logic [LED_W-1:0] START_SHR   = 4'b1000;
    localparam logic [LED_W-1:0] START_PING  = 4'b0001;
    localparam logic [LED_W-1:0] START_BLINK = 4'b1111;

    function automatic logic [LED_W-1:0] start_pattern(input mode_e mode);
        logic [LED_W-1:0] pat;
        case (mode)
            MODE_SHL:   pat = START_SHL;
            MODE_SHR:   pat = START_SHR;
            MODE_PING:  pat = START_PING;
            MODE_BLINK: pat = START_BLINK;
            default:    pat = START_SHL;
        endcase
        return pat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/led_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : led_tick_gen
//  Brief    : Step prescaler; counts 0..CNT_MAX while enabled and flags the
//             terminal count. Held at zero while disabled.
//  Revision : 1.0 - initial release
// ============================================================================
module led_tick_gen #(
    parameter logic [24:0] CNT_MAX = 25'd24_999_999
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic en,
    output logic tick
);

    logic [24:0] r_cnt;

    always_ff @(posedge sys_clk) begin
        if (sys_rst || !en) begin
            r_cnt <= '0;
        end else if (r_cnt == CNT_MAX) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 25'd1;
        end
    end

    assign tick = en && (r_cnt == CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/led_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : led_seq_ctrl
//  Brief    : 4-LED mode scheduler; mode changes land only on step ticks.
//             Optional brightness PWM enabled by LED_SEQ_BRIGHT_PWM_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module led_seq_ctrl
    import led_pkg::*;
#(
    parameter logic [24:0] CNT_MAX  = 25'd24_999_999,
    parameter logic [3:0]  PWM_DUTY = 4'd8
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             run_en,
    input  logic             mode_req,
    input  logic [1:0]       mode_sel,
    output logic             mode_ack,
    output logic [1:0]       cur_mode,
    output logic             tick_out,
    output logic [LED_W-1:0] led_out
);

    state_e           r_state;
    mode_e            r_cur_mode;
    mode_e            r_pend_mode;
    logic             r_pending;
    logic             r_mode_ack;
    logic             r_dir_down;
    logic [LED_W-1:0] r_pattern;

    logic             w_tick;
    logic             w_req_valid;
    mode_e            w_req_mode;
    logic [LED_W-1:0] w_step_pattern;
    logic             w_step_dir_down;

    led_tick_gen #(
        .CNT_MAX (CNT_MAX)
    ) u_tick_gen (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .en      (r_state == RUN),
        .tick    (w_tick)
    );

    // A request arriving in the same cycle as the tick is treated as pending.
    assign w_req_valid = mode_req | r_pending;
    assign w_req_mode  = mode_req ? mode_e'(mode_sel) : r_pend_mode;

    always_comb begin
        w_step_pattern  = r_pattern;
        w_step_dir_down = r_dir_down;
        case (r_cur_mode)
            MODE_SHL:   w_step_pattern = {r_pattern[LED_W-2:0], r_pattern[LED_W-1]};
            MODE_SHR:   w_step_pattern = {r_pattern[0], r_pattern[LED_W-1:1]};
            MODE_PING: begin
                if (!r_dir_down) begin
                    w_step_pattern  = r_pattern << 1;
                    w_step_dir_down = (w_step_pattern == 4'b1000);
                end else begin
                    w_step_pattern  = r_pattern >> 1;
                    w_step_dir_down = (w_step_pattern != 4'b0001);
                end
            end
            MODE_BLINK: w_step_pattern = ~r_pattern;
            default:    w_step_pattern = r_pattern;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state     <= IDLE;
            r_cur_mode  <= MODE_SHL;
            r_pend_mode <= MODE_SHL;
            r_pending   <= 1'b0;
            r_mode_ack  <= 1'b0;
            r_dir_down  <= 1'b0;
            r_pattern   <= '0;
        end else begin
            r_mode_ack <= 1'b0;
            if (mode_req) begin
                r_pending   <= 1'b1;
                r_pend_mode <= mode_e'(mode_sel);
            end
            case (r_state)
                IDLE: begin
                    r_pattern <= '0;
                    if (w_req_valid) begin
                        r_cur_mode <= w_req_mode;
                        r_pending  <= 1'b0;
                        r_mode_ack <= 1'b1;
                    end
                    if (run_en) begin
                        r_state    <= RUN;
                        r_dir_down <= 1'b0;
                        r_pattern  <= start_pattern(w_req_valid ? w_req_mode : r_cur_mode);
                    end
                end
                RUN: begin
                    if (!run_en) begin
                        r_state   <= IDLE;
                        r_pattern <= '0;
                    end else if (w_tick) begin
                        if (w_req_valid) begin
                            r_cur_mode <= w_req_mode;
                            r_pending  <= 1'b0;
                            r_mode_ack <= 1'b1;
                            r_dir_down <= 1'b0;
                            r_pattern  <= start_pattern(w_req_mode);
                        end else begin
                            r_pattern  <= w_step_pattern;
                            r_dir_down <= w_step_dir_down;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mode_ack = r_mode_ack;
    assign cur_mode = r_cur_mode;
    assign tick_out = w_tick;

`ifdef LED_SEQ_BRIGHT_PWM_EN
    logic [3:0] r_pwm_cnt;
    logic       w_pwm_on;

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_pwm_cnt <= 4'd0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 4'd1;
        end
    end

    assign w_pwm_on = (r_pwm_cnt < PWM_DUTY);
    assign led_out  = ~(r_pattern & {LED_W{w_pwm_on}});
`else
    logic w_unused_pwm_duty;
    assign w_unused_pwm_duty = ^PWM_DUTY;
    assign led_out           = ~r_pattern;
`endif

endmodule
`default_nettype wire

// File: tb/tb_led_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_led_seq_ctrl
//  Brief    : Directed self-checking bench for led_seq_ctrl with CNT_MAX=4.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_led_seq_ctrl;

    logic       sys_clk = 1'b0;
    logic       sys_rst;
    logic       run_en;
    logic       mode_req;
    logic [1:0] mode_sel;
    logic       mode_ack;
    logic [1:0] cur_mode;
    logic       tick_out;
    logic [3:0] led_out;

    int n_vec = 0;
    int n_err = 0;

    led_seq_ctrl #(
        .CNT_MAX  (25'd4),
        .PWM_DUTY (4'd4)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst  (sys_rst),
        .run_en   (run_en),
        .mode_req (mode_req),
        .mode_sel (mode_sel),
        .mode_ack (mode_ack),
        .cur_mode (cur_mode),
        .tick_out (tick_out),
        .led_out  (led_out)
    );

    always #5 sys_clk = ~sys_clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic test_reset();
        sys_rst = 1'b1; run_en = 1'b0; mode_req = 1'b0; mode_sel = 2'd0;
        step(3);
        n_vec++; if (led_out !== 4'b1111) begin n_err++; $display("FAIL rst_led: got %b expected 1111", led_out); end
        n_vec++; if (tick_out !== 1'b0) begin n_err++; $display("FAIL rst_tick: got %b expected 0", tick_out); end
        n_vec++; if (mode_ack !== 1'b0) begin n_err++; $display("FAIL rst_ack: got %b expected 0", mode_ack); end
        n_vec++; if (cur_mode !== 2'd0) begin n_err++; $display("FAIL rst_mode: got %0d expected 0", cur_mode); end
        sys_rst = 1'b0;
        step(1);
        n_vec++; if (led_out !== 4'b1111) begin n_err++; $display("FAIL idle_led: got %b expected 1111", led_out); end
    endtask

    task automatic test_shl();
        logic [3:0] exp_led [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        run_en = 1'b1;
        step(1);
        for (int i = 0; i < 5; i++) begin
            n_vec++; if (led_out !== exp_led[i] || tick_out !== 1'b0) begin n_err++; $display("FAIL shl_step%0d: got led %b tick %b expected led %b tick 0", i, led_out, tick_out, exp_led[i]); end
            step(4);
            n_vec++; if (led_out !== exp_led[i] || tick_out !== 1'b1) begin n_err++; $display("FAIL shl_tick%0d: got led %b tick %b expected led %b tick 1", i, led_out, tick_out, exp_led[i]); end
            step(1);
        end
    endtask

    task automatic test_ping_switch();
        logic [3:0] exp_led [6] = '{4'b1101, 4'b1011, 4'b0111, 4'b1011, 4'b1101, 4'b1110};
        step(2);
        mode_req = 1'b1; mode_sel = 2'd2;
        step(1);
        mode_req = 1'b0;
        n_vec++; if (mode_ack !== 1'b0 || cur_mode !== 2'd0) begin n_err++; $display("FAIL ping_early: got ack %b mode %0d expected ack 0 mode 0", mode_ack, cur_mode); end
        step(1);
        n_vec++; if (tick_out !== 1'b1 || led_out !== 4'b1101) begin n_err++; $display("FAIL ping_pretick: got tick %b led %b expected tick 1 led 1101", tick_out, led_out); end
        step(1);
        n_vec++; if (mode_ack !== 1'b1 || cur_mode !== 2'd2 || led_out !== 4'b1110) begin n_err++; $display("FAIL ping_apply: got ack %b mode %0d led %b expected ack 1 mode 2 led 1110", mode_ack, cur_mode, led_out); end
        step(1);
        n_vec++; if (mode_ack !== 1'b0) begin n_err++; $display("FAIL ping_ack_len: got %b expected 0", mode_ack); end
        step(4);
        for (int i = 0; i < 6; i++) begin
            n_vec++; if (led_out !== exp_led[i]) begin n_err++; $display("FAIL ping_seq%0d: got %b expected %b", i, led_out, exp_led[i]); end
            step(5);
        end
    endtask

    task automatic test_latest_wins();
        step(1);
        mode_req = 1'b1; mode_sel = 2'd1;
        step(1);
        n_vec++; if (mode_ack !== 1'b0) begin n_err++; $display("FAIL latest_ack1: got %b expected 0", mode_ack); end
        mode_sel = 2'd3;
        step(1);
        mode_req = 1'b0;
        n_vec++; if (mode_ack !== 1'b0) begin n_err++; $display("FAIL latest_ack2: got %b expected 0", mode_ack); end
        step(2);
        n_vec++; if (mode_ack !== 1'b1 || cur_mode !== 2'd3 || led_out !== 4'b0000) begin n_err++; $display("FAIL latest_apply: got ack %b mode %0d led %b expected ack 1 mode 3 led 0000", mode_ack, cur_mode, led_out); end
        step(1);
        n_vec++; if (mode_ack !== 1'b0) begin n_err++; $display("FAIL latest_single: got %b expected 0", mode_ack); end
        step(4);
        n_vec++; if (led_out !== 4'b1111) begin n_err++; $display("FAIL blink_1: got %b expected 1111", led_out); end
        step(5);
        n_vec++; if (led_out !== 4'b0000) begin n_err++; $display("FAIL blink_2: got %b expected 0000", led_out); end
    endtask

    task automatic test_run_en();
        step(2);
        run_en = 1'b0;
        step(1);
        n_vec++; if (led_out !== 4'b1111 || tick_out !== 1'b0) begin n_err++; $display("FAIL stop_led: got led %b tick %b expected led 1111 tick 0", led_out, tick_out); end
        for (int i = 0; i < 10; i++) begin
            step(1);
            n_vec++; if (led_out !== 4'b1111 || tick_out !== 1'b0) begin n_err++; $display("FAIL idle_hold%0d: got led %b tick %b expected led 1111 tick 0", i, led_out, tick_out); end
        end
        run_en = 1'b1;
        step(1);
        n_vec++; if (led_out !== 4'b0000 || cur_mode !== 2'd3) begin n_err++; $display("FAIL restart: got led %b mode %0d expected led 0000 mode 3", led_out, cur_mode); end
        step(3);
        n_vec++; if (tick_out !== 1'b0) begin n_err++; $display("FAIL restart_early_tick: got %b expected 0", tick_out); end
        step(1);
        n_vec++; if (tick_out !== 1'b1 || led_out !== 4'b0000) begin n_err++; $display("FAIL restart_tick: got tick %b led %b expected tick 1 led 0000", tick_out, led_out); end
        step(1);
        n_vec++; if (led_out !== 4'b1111) begin n_err++; $display("FAIL restart_step: got %b expected 1111", led_out); end
    endtask

    task automatic test_same_cycle_and_reset();
        step(4);
        mode_req = 1'b1; mode_sel = 2'd1;
        n_vec++; if (tick_out !== 1'b1) begin n_err++; $display("FAIL same_tick: got %b expected 1", tick_out); end
        step(1);
        mode_req = 1'b0;
        n_vec++; if (led_out !== 4'b0111 || mode_ack !== 1'b1 || cur_mode !== 2'd1) begin n_err++; $display("FAIL same_apply: got led %b ack %b mode %0d expected led 0111 ack 1 mode 1", led_out, mode_ack, cur_mode); end
        step(2);
        sys_rst = 1'b1;
        step(1);
        n_vec++; if (led_out !== 4'b1111 || tick_out !== 1'b0 || mode_ack !== 1'b0 || cur_mode !== 2'd0) begin n_err++; $display("FAIL midrst: got led %b tick %b ack %b mode %0d expected 1111 0 0 0", led_out, tick_out, mode_ack, cur_mode); end
        sys_rst = 1'b0;
        step(1);
        n_vec++; if (led_out !== 4'b1110 || cur_mode !== 2'd0) begin n_err++; $display("FAIL post_rst: got led %b mode %0d expected led 1110 mode 0", led_out, cur_mode); end
    endtask

    task automatic test_idle_and_same_mode();
        run_en = 1'b0;
        step(1);
        mode_req = 1'b1; mode_sel = 2'd2;
        step(1);
        mode_req = 1'b0;
        n_vec++; if (mode_ack !== 1'b1 || cur_mode !== 2'd2 || led_out !== 4'b1111) begin n_err++; $display("FAIL idle_apply: got ack %b mode %0d led %b expected ack 1 mode 2 led 1111", mode_ack, cur_mode, led_out); end
        step(1);
        n_vec++; if (mode_ack !== 1'b0) begin n_err++; $display("FAIL idle_ack_len: got %b expected 0", mode_ack); end
        run_en = 1'b1;
        step(1);
        n_vec++; if (led_out !== 4'b1110) begin n_err++; $display("FAIL ping_start: got %b expected 1110", led_out); end
        step(5);
        n_vec++; if (led_out !== 4'b1101) begin n_err++; $display("FAIL ping_first: got %b expected 1101", led_out); end
        step(2);
        mode_req = 1'b1; mode_sel = 2'd2;
        step(1);
        mode_req = 1'b0;
        step(2);
        n_vec++; if (mode_ack !== 1'b1 || led_out !== 4'b1110 || cur_mode !== 2'd2) begin n_err++; $display("FAIL same_mode: got ack %b led %b mode %0d expected ack 1 led 1110 mode 2", mode_ack, led_out, cur_mode); end
    endtask

`ifdef LED_SEQ_BRIGHT_PWM_EN
    task automatic test_pwm();
        logic [3:0] one;
        logic [3:0] exp_on;
        int         lows;
        one  = 4'b0001;
        lows = 0;
        run_en = 1'b1;
        step(1);
        for (int i = 0; i < 16; i++) begin
            exp_on = ~(one << ((i / 5) % 4));
            n_vec++; if (led_out !== 4'b1111 && led_out !== exp_on) begin n_err++; $display("FAIL pwm_shape%0d: got %b expected 1111 or %b", i, led_out, exp_on); end
            if (led_out !== 4'b1111) lows++;
            step(1);
        end
        n_vec++; if (lows != 4) begin n_err++; $display("FAIL pwm_duty: got %0d lit slots expected 4", lows); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef LED_SEQ_BRIGHT_PWM_EN
        test_pwm();
`else
        test_shl();
        test_ping_switch();
        test_latest_wins();
        test_run_en();
        test_same_cycle_and_reset();
        test_idle_and_same_mode();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
